spi_mem_target: RTL and testbench
=================================

# spi_mem_target

SPI responder that emulates a small byte-addressable SPI RAM inside the design. It accepts the same mode-0, MSB-first READ (0x03) / WRITE (0x02) framing with 16-bit address that the SPI controller issues. It serves as the far end of the controller for loopback and self-test, and as an on-chip scratch RAM reachable over the spare chip-select outputs. All SPI pins are oversampled in the `clk` domain; there is no second clock.

## Interface
- `DEPTH_BITS`, default 6: log2 of storage size in bytes (64 bytes). Only the low `DEPTH_BITS` of the 16-bit address are used.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low. The block has one clock; reset is asynchronous and active-low.
- `sclk` in 1: SPI clock from the controller, asynchronous to `clk`.
- `cs_n` in 1: chip select, active-low, asynchronous.
- `mosi` in 1: serial data in.
- `miso` out 1: serial data out.
- `miso_oe` out 1: high while the block is selected (synchronized `cs_n` low).
- `busy` out 1: high while a transaction is in progress (any state other than IDLE).
- `cmd_err` out 1: one-`clk` pulse when an unsupported command byte completes.

## Operation
- **Synchronization:** `sclk`, `cs_n` and `mosi` each pass through a 2-flop synchronizer.
  - A third `sclk` flop provides rise/fall edge detection.
  - All logic acts on the synchronized signals only.
- **Requirements on the initiator:** `sclk` high and low phases are each ≥3 `clk` periods; `mosi` is stable around rising `sclk`.
- **Bit handling:** `mosi` is sampled on detected `sclk` rise. `miso` changes only on detected `sclk` fall. Bits are MSB first.
- **Bit counter:** 3 bits, cleared on `cs_n` assertion; it wraps 7→0 at each byte boundary.
- **States:** IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, IGNORE.
  - IDLE→CMD on synchronized `cs_n` falling.
  - CMD→ADDR_HI after 8 bits if the byte is 0x02 or 0x03.
  - CMD→IGNORE for any other byte, with `cmd_err` pulsed.
  - ADDR_HI→ADDR_LO after 8 bits.
  - ADDR_LO→RD_DATA (cmd 0x03) or WR_DATA (cmd 0x02) after 8 bits.
  - Any state→IDLE on synchronized `cs_n` high.
- **Address pointer:** `DEPTH_BITS` wide, loaded from `{addr_hi, addr_lo}[DEPTH_BITS-1:0]` when ADDR_LO completes. Increments modulo 2^`DEPTH_BITS` (wraps to 0) after every data byte.
- **Read (RD_DATA):**
  - On the clock after the address completes, load `mem[ptr]` into the tx shift register and increment `ptr`.
  - Drive the MSB on the next `sclk` fall, then shift one bit per fall.
  - After the 8th rising edge of a byte, reload from `mem[ptr]` and increment again. Reads stream indefinitely with wrap.
- **Write (WR_DATA):** on each completed 8th bit, write the assembled byte to `mem[ptr]` and increment `ptr`. Partial bytes are never written.
- **`miso` outside RD_DATA:** driven 0 (CMD, ADDR_*, WR_DATA, IGNORE, IDLE).
- **Deselect mid-byte:** abandons the byte. No memory write occurs and the bit counter clears.
- **Storage reset:** storage is flops with async reset to 0x00. Reset mid-transaction clears state, pointer, shift registers and memory.
- **Host-side bus:** none. Storage is accessible only via SPI.

## Timing
- **Reset values:** `miso`=0, `miso_oe`=0, `busy`=0, `cmd_err`=0, state IDLE, `ptr`=0, memory all 0x00.
- **Input latency:** a pin edge is acted on 3 `clk` cycles after it occurs (2 synchronizer stages + edge detect).
- **`miso` update:** registered; valid 1 `clk` after the detected `sclk` fall, i.e. ≤4 `clk` after the pin edge. This is why each `sclk` half-period must be ≥3 `clk`.
- **`busy` and `miso_oe`:** rise 3 `clk` after `cs_n` falls; fall 3 `clk` after `cs_n` rises.
- **`cmd_err`:** asserted exactly 1 `clk` on the cycle after the 8th command bit is sampled.
- **Memory write:** takes effect on the cycle after the 8th data bit is sampled.
- **Simultaneous events:** if synchronized `cs_n` rises on the same cycle as a detected `sclk` rise, deselect wins and the bit is discarded.
- **Wrap-around:** `ptr` = 2^`DEPTH_BITS`−1 followed by one data byte gives `ptr` = 0; there is no error flag.

## Test plan
- **Write then read back:** WRITE 0x02, addr 0x0005, data 0xA5 0x3C, deselect; then READ 0x03, addr 0x0005, 2 bytes → `miso` returns 0xA5, 0x3C; `cmd_err` stays 0.
- **Wrap-around:** WRITE at addr 0x003F with bytes 0x11, 0x22 → `mem[63]`=0x11, `mem[0]`=0x22. READ at 0x003F for 2 bytes returns 0x11, 0x22.
- **Address aliasing:** READ at addr 0xFFC5 aliases to addr 5 and returns the byte previously written there.
- **Bad command:** command byte 0x9F → `cmd_err` 1-cycle pulse, `miso` held 0 for the rest of the frame, memory unchanged, `busy` drops 3 `clk` after `cs_n` rises.
- **Mid-byte deselect:** WRITE at addr 0x0010, 5 data bits, then `cs_n` high → `mem[16]` unchanged. The next transaction starts correctly in CMD.
- **Reset mid-transaction:** `rst_n` asserted during RD_DATA → all outputs 0 immediately and memory reads back 0x00 after release. Also verify `sclk` at the minimum 3+3 `clk` period with random `cs_n` gaps passes a 64-byte write/readback.

Source files
------------

// File: rtl/spi_mem_target_if.sv
// ----------------------------------------------------------------------------
// spi_mem_target_if
// Serial-pin bundle between an SPI initiator and the spi_mem_target responder.
//   sclk    : SPI clock (initiator -> target), async to the target's clk
//   cs_n    : chip select, active-low (initiator -> target)
//   mosi    : serial data towards the target
//   miso    : serial data from the target
//   miso_oe : target is selected and driving miso
//   busy    : target has a transaction in progress
//   cmd_err : one-cycle pulse on an unsupported command byte
// Modports: master = initiator side, slave = target side.
// ----------------------------------------------------------------------------
interface spi_mem_target_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic busy;
  logic cmd_err;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, miso_oe, busy, cmd_err
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, miso_oe, busy, cmd_err
  );
endinterface

// File: rtl/spi_mem_target.sv
// ----------------------------------------------------------------------------
// spi_mem_target
// SPI mode-0, MSB-first responder emulating a small byte-addressable RAM.
// Commands: 0x03 READ, 0x02 WRITE, each followed by a 16-bit address; only the
// low DEPTH_BITS address bits select a byte. All SPI pins are oversampled in
// the clk domain.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (clears state and storage)
//   spi   : slave modport of spi_mem_target_if (sclk, cs_n, mosi in;
//           miso, miso_oe, busy, cmd_err out, all registered)
// ----------------------------------------------------------------------------
module spi_mem_target #(
  parameter int DEPTH_BITS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_mem_target_if.slave spi
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR_HI = 3'd2,
    ST_ADDR_LO = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_WR_DATA = 3'd5,
    ST_IGNORE  = 3'd6
  } state_t;

  // Synchronizer and edge-detect flops
  logic sclk_q1_r, sclk_q2_r, sclk_q3_r;
  logic cs_q1_r, cs_q2_r, cs_q3_r;
  logic mosi_q1_r, mosi_q2_r;

  // Protocol state
  state_t                state_r;
  logic [2:0]            bit_cnt_r;
  logic [6:0]            rx_shift_r;   // only 7 bits kept; the 8th is mosi itself
  logic [7:0]            tx_shift_r;
  logic [DEPTH_BITS-1:0] addr_sr_r;    // low address bits shifted in over both address bytes
  logic [DEPTH_BITS-1:0] ptr_r;
  logic                  read_cmd_r;
  logic                  load_r;       // fetch mem[ptr] into tx_shift_r on this cycle
  logic [7:0]            mem_r [DEPTH];

  // Registered outputs
  logic miso_r, miso_oe_r, busy_r, cmd_err_r;

  logic                  sclk_rise_s;
  logic                  sclk_fall_s;
  logic                  cs_fall_s;
  logic [7:0]            byte_s;
  logic                  byte_done_s;
  logic [DEPTH_BITS-1:0] addr_next_s;

  assign sclk_rise_s = sclk_q2_r & ~sclk_q3_r;
  assign sclk_fall_s = ~sclk_q2_r & sclk_q3_r;
  assign cs_fall_s   = cs_q3_r & ~cs_q2_r;
  assign byte_s      = {rx_shift_r, mosi_q2_r};
  assign byte_done_s = sclk_rise_s && (bit_cnt_r == 3'd7) && (state_r != ST_IDLE);
  assign addr_next_s = {addr_sr_r[DEPTH_BITS-2:0], mosi_q2_r};

  assign spi.miso    = miso_r;
  assign spi.miso_oe = miso_oe_r;
  assign spi.busy    = busy_r;
  assign spi.cmd_err = cmd_err_r;

  // Two-stage synchronizers for all pins plus one extra stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q1_r <= 1'b0;
      sclk_q2_r <= 1'b0;
      sclk_q3_r <= 1'b0;
      cs_q1_r   <= 1'b1;
      cs_q2_r   <= 1'b1;
      cs_q3_r   <= 1'b1;
      mosi_q1_r <= 1'b0;
      mosi_q2_r <= 1'b0;
    end else begin
      sclk_q1_r <= spi.sclk;
      sclk_q2_r <= sclk_q1_r;
      sclk_q3_r <= sclk_q2_r;
      cs_q1_r   <= spi.cs_n;
      cs_q2_r   <= cs_q1_r;
      cs_q3_r   <= cs_q2_r;
      mosi_q1_r <= spi.mosi;
      mosi_q2_r <= mosi_q1_r;
    end
  end

  // Transaction FSM, shift registers, pointer, storage and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 7'd0;
      tx_shift_r <= 8'h00;
      addr_sr_r  <= {DEPTH_BITS{1'b0}};
      ptr_r      <= {DEPTH_BITS{1'b0}};
      read_cmd_r <= 1'b0;
      load_r     <= 1'b0;
      miso_r     <= 1'b0;
      miso_oe_r  <= 1'b0;
      busy_r     <= 1'b0;
      cmd_err_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      cmd_err_r <= 1'b0;
      miso_oe_r <= ~cs_q2_r;

      if (cs_q2_r) begin
        // Deselect has priority over any sclk edge in the same cycle, so a
        // partial byte is dropped and never written.
        state_r   <= ST_IDLE;
        busy_r    <= 1'b0;
        bit_cnt_r <= 3'd0;
        load_r    <= 1'b0;
        miso_r    <= 1'b0;
      end else begin
        if (load_r) begin
          tx_shift_r <= mem_r[ptr_r];
          ptr_r      <= ptr_r + PTR_ONE;
          load_r     <= 1'b0;
        end

        if ((state_r != ST_IDLE) && sclk_rise_s) begin
          rx_shift_r <= byte_s[6:0];
          bit_cnt_r  <= bit_cnt_r + 3'd1;
        end

        if (state_r == ST_RD_DATA) begin
          if (sclk_fall_s) begin
            miso_r     <= tx_shift_r[7];
            tx_shift_r <= {tx_shift_r[6:0], 1'b0};
          end
        end else begin
          miso_r <= 1'b0;
        end

        case (state_r)
          ST_IDLE: begin
            if (cs_fall_s) begin
              state_r   <= ST_CMD;
              busy_r    <= 1'b1;
              bit_cnt_r <= 3'd0;
            end
          end
          ST_CMD: begin
            if (byte_done_s) begin
              if ((byte_s == 8'h02) || (byte_s == 8'h03)) begin
                read_cmd_r <= byte_s[0];
                state_r    <= ST_ADDR_HI;
              end else begin
                cmd_err_r <= 1'b1;
                state_r   <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_HI: begin
            if (sclk_rise_s) begin
              addr_sr_r <= addr_next_s;
            end
            if (byte_done_s) begin
              state_r <= ST_ADDR_LO;
            end
          end
          ST_ADDR_LO: begin
            if (sclk_rise_s) begin
              addr_sr_r <= addr_next_s;
            end
            if (byte_done_s) begin
              ptr_r <= addr_next_s;
              if (read_cmd_r) begin
                state_r <= ST_RD_DATA;
                load_r  <= 1'b1;
              end else begin
                state_r <= ST_WR_DATA;
              end
            end
          end
          ST_RD_DATA: begin
            if (byte_done_s) begin
              load_r <= 1'b1;
            end
          end
          ST_WR_DATA: begin
            if (byte_done_s) begin
              mem_r[ptr_r] <= byte_s;
              ptr_r        <= ptr_r + PTR_ONE;
            end
          end
          ST_IGNORE: begin
            state_r <= ST_IGNORE;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_target.sv
// ----------------------------------------------------------------------------
// tb_spi_mem_target
// Directed bench for spi_mem_target: drives SPI frames from the initiator
// side of the interface and compares miso data and status outputs against
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_spi_mem_target;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  spi_mem_target_if spi_if ();

  spi_mem_target #(.DEPTH_BITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (spi_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cmd_err_cycles = 0;
  int half = 4;

  // Counts clk cycles during which cmd_err is high
  always @(negedge clk) begin
    if (spi_if.cmd_err === 1'b1) cmd_err_cycles++;
  end

  // Safety net: the run must never hang
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_if.mosi = tx[i];
      repeat (half) @(negedge clk);
      rx[i] = spi_if.miso;
      spi_if.sclk = 1'b1;
      repeat (half) @(negedge clk);
      spi_if.sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    xfer_bits(tx, 8, rx);
  endtask

  // Assert cs_n and check busy / miso_oe rise exactly 3 clk later
  task automatic start_frame(input string tag);
    spi_if.cs_n = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_busy_early"}, spi_if.busy, 1'b0);
    @(negedge clk);
    check({tag, "_busy_rise"}, spi_if.busy, 1'b1);
    check({tag, "_oe_rise"}, spi_if.miso_oe, 1'b1);
  endtask

  // Deassert cs_n and check busy / miso_oe fall exactly 3 clk later
  task automatic end_frame(input string tag, input int gap);
    repeat (half) @(negedge clk);
    spi_if.cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_busy_hold"}, spi_if.busy, 1'b1);
    @(negedge clk);
    check({tag, "_busy_fall"}, spi_if.busy, 1'b0);
    check({tag, "_oe_fall"}, spi_if.miso_oe, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr);
    logic [7:0] rx;
    xfer(cmd, rx);
    xfer(addr[15:8], rx);
    xfer(addr[7:0], rx);
  endtask

  task automatic wr_bytes(input string tag, input logic [15:0] addr, input logic [7:0] d0,
                          input logic [7:0] d1, input int n);
    logic [7:0] rx;
    start_frame(tag);
    send_hdr(8'h02, addr);
    xfer(d0, rx);
    if (n > 1) xfer(d1, rx);
    end_frame(tag, 4);
  endtask

  task automatic rd_check(input string tag, input logic [15:0] addr, input logic [7:0] e0,
                          input logic [7:0] e1, input logic [7:0] e2, input int n);
    logic [7:0] rx;
    logic [7:0] exp_b [3];
    exp_b[0] = e0;
    exp_b[1] = e1;
    exp_b[2] = e2;
    start_frame(tag);
    send_hdr(8'h03, addr);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, rx);
      check($sformatf("%s_b%0d", tag, k), rx, exp_b[k]);
    end
    end_frame(tag, 4);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] pat;
    spi_if.sclk = 1'b0;
    spi_if.cs_n = 1'b1;
    spi_if.mosi = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_miso", spi_if.miso, 1'b0);
    check("rst_oe", spi_if.miso_oe, 1'b0);
    check("rst_busy", spi_if.busy, 1'b0);
    check("rst_cmd_err", spi_if.cmd_err, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Write then read back
    wr_bytes("wr5", 16'h0005, 8'hA5, 8'h3C, 2);
    rd_check("rd5", 16'h0005, 8'hA5, 8'h3C, 8'h00, 2);
    check("no_cmd_err", cmd_err_cycles, 0);

    // Wrap-around at the top of storage
    wr_bytes("wr3f", 16'h003F, 8'h11, 8'h22, 2);
    rd_check("rd3f", 16'h003F, 8'h11, 8'h22, 8'h00, 3);
    rd_check("rd0", 16'h0000, 8'h22, 8'h00, 8'h00, 1);

    // Upper address bits are ignored
    rd_check("alias", 16'hFFC5, 8'hA5, 8'h3C, 8'h00, 2);

    // Unsupported command: one cmd_err pulse, miso held low
    start_frame("bad");
    xfer(8'h9F, rx);
    check("bad_cmd_miso", rx, 8'h00);
    for (int k = 0; k < 3; k++) begin
      xfer(8'hFF, rx);
      check($sformatf("bad_miso_b%0d", k), rx, 8'h00);
    end
    end_frame("bad", 4);
    check("bad_cmd_err_cycles", cmd_err_cycles, 1);
    rd_check("bad_mem", 16'h0005, 8'hA5, 8'h00, 8'h00, 1);

    // Mid-byte deselect must not write
    wr_bytes("wr10", 16'h0010, 8'h5A, 8'h00, 1);
    start_frame("part");
    send_hdr(8'h02, 16'h0010);
    xfer_bits(8'hFF, 5, rx);
    end_frame("part", 4);
    rd_check("rd10", 16'h0010, 8'h5A, 8'h00, 8'h00, 1);
    check("cmd_err_after_part", cmd_err_cycles, 1);

    // Reset in the middle of a read
    start_frame("rstrd");
    send_hdr(8'h03, 16'h0005);
    repeat (half) @(negedge clk);
    check("rstrd_msb", spi_if.miso, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstrd_miso", spi_if.miso, 1'b0);
    check("rstrd_oe", spi_if.miso_oe, 1'b0);
    check("rstrd_busy", spi_if.busy, 1'b0);
    check("rstrd_cmd_err", spi_if.cmd_err, 1'b0);
    spi_if.cs_n = 1'b1;
    spi_if.sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd_check("clr5", 16'h0005, 8'h00, 8'h00, 8'h00, 2);
    rd_check("clr3f", 16'h003F, 8'h00, 8'h00, 8'h00, 1);
    rd_check("clr10", 16'h0010, 8'h00, 8'h00, 8'h00, 1);

    // Minimum sclk period, full 64-byte write/readback with random gaps
    half = 3;
    for (int f = 0; f < 4; f++) begin
      start_frame("fw");
      send_hdr(8'h02, 16'(f * 16));
      for (int i = 0; i < 16; i++) begin
        pat = 8'((f * 16 + i) * 37 + 11);
        xfer(pat, rx);
      end
      end_frame("fw", int'($urandom_range(2, 12)));
    end
    for (int f = 0; f < 2; f++) begin
      start_frame("fr");
      send_hdr(8'h03, 16'(f * 32));
      for (int i = 0; i < 32; i++) begin
        pat = 8'((f * 32 + i) * 37 + 11);
        xfer(8'h00, rx);
        check($sformatf("full_%0d", f * 32 + i), rx, pat);
      end
      end_frame("fr", int'($urandom_range(2, 12)));
    end
    check("final_cmd_err", cmd_err_cycles, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
